lc3_dmem_responder: RTL and testbench
=====================================

Name: lc3_dmem_responder

Overview:
- Data-memory responder for the LC3 MemAccess stage bus. It is the far end of the memaccess_out signals.
- Samples DMem_addr, DMem_din, DMem_rd and mem_state, stores writes, and returns read data on DMem_dout after a programmable latency.
- Sits between the MemAccess stage (or its initiator agent) and the testbench/SoC data-memory model. Provides access statistics and protocol-error flags to the scoreboard.

Parameters:
- ADDR_WIDTH, 8, number of implemented word-address bits (memory depth 2**ADDR_WIDTH x 16).
- READ_LATENCY, 1, cycles from request sample to DMem_dout valid; legal range 1..15.
- PROT_BASE, 16'h00F0, first write-protected word address (used only with the optional feature).

Ports:
- clock  input  1  single clock; all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- DMem_addr  input  16  word address from MemAccess.
- DMem_din  input  16  write data.
- DMem_rd  input  1  1 = read, 0 = write.
- mem_state  input  2  0 = read, 1 = indirect read, 2 = write, 3 = idle.
- DMem_dout  output  16  read data returned to MemAccess.
- dout_valid  output  1  one-cycle pulse when DMem_dout is updated.
- busy  output  1  high while a read is in flight.
- rd_count  output  16  completed reads, saturating.
- wr_count  output  16  committed writes, saturating.
- proto_err  output  1  sticky error flag.

Behaviour:
- Reset (synchronous, active-high, dominant over everything):
  - DMem_dout = 16'h0000; dout_valid = 0; busy = 0; counters = 0; proto_err = 0; FSM = IDLE.
  - Memory array is not cleared.
  - Reset mid-read aborts the read: no dout_valid and no count.
- Request detection: a request exists when mem_state != 3.
  - Read request: mem_state in {0,1} with DMem_rd = 1.
  - Write request: mem_state = 2 with DMem_rd = 0.
  - Any other mem_state/DMem_rd combination sets proto_err; no access occurs.
- FSM states: IDLE, RD_WAIT, RESP.
  - IDLE, read request at edge k: latch address, load latency counter = READ_LATENCY-1, busy = 1. Go to RESP if READ_LATENCY = 1, else RD_WAIT.
  - RD_WAIT: decrement the counter each cycle; go to RESP when it reaches 0.
  - RESP: at edge k+READ_LATENCY, DMem_dout = mem[latched addr], dout_valid = 1 for exactly one cycle, rd_count++, busy = 0, return to IDLE. IDLE may accept a new request on the following edge.
- Writes (IDLE only): mem[addr] <= DMem_din at the sampling edge. Zero latency; wr_count++. No dout_valid.
- Read-after-write: a read sampled at edge k+1 returns data written at edge k.
- DMem_dout holds its last value between reads.
- Request while busy (RD_WAIT or RESP): ignored, proto_err set; a write is not committed.
- Out-of-range address (any bit above ADDR_WIDTH-1 set): read returns 16'h0000 with normal latency and counts; write is dropped and not counted; proto_err set.
- Counters saturate at 16'hFFFF; no wrap.
- Indirect read (mem_state = 1) uses identical timing; the second access arrives as a separate mem_state = 0 request.

Optional Feature:
- Macro: DMEM_WRITE_PROTECT_EN.
- Defined: writes to addresses >= PROT_BASE are not committed, are not counted, and set proto_err. Reads are unaffected.
- Undefined: all in-range addresses are writable and PROT_BASE is ignored.

Decomposition:
- Shared package lc3_dmem_pkg holds:
  - mem_state_t enum: MEM_RD = 2'd0, MEM_RDI = 2'd1, MEM_WR = 2'd2, MEM_IDLE = 2'd3.
  - dmem_fsm_t enum: IDLE, RD_WAIT, RESP.
  - Constants: DATA_W = 16, CNT_MAX = 16'hFFFF.
- One sub-module, lc3_dmem_sat_counter: 16-bit saturating counter with synchronous clear, instantiated twice (rd_count, wr_count).

Test Plan:
- Write 16'hBEEF at 16'h0010 (mem_state = 2, DMem_rd = 0), then read 16'h0010 next cycle with READ_LATENCY = 3 -> dout_valid pulses 3 cycles after sample, DMem_dout = 16'hBEEF, wr_count = 1, rd_count = 1.
- Read request issued while busy -> request ignored, proto_err = 1, rd_count increments once only.
- Read at 16'h0100 with ADDR_WIDTH = 8 -> DMem_dout = 16'h0000 after latency, proto_err = 1; write to the same address -> mem unchanged, wr_count unchanged.
- Assert reset during RD_WAIT -> no dout_valid, busy = 0, DMem_dout = 16'h0000, counters = 0; memory contents retained (read of 16'h0010 still returns 16'hBEEF).
- With DMEM_WRITE_PROTECT_EN defined: write 16'h1234 to 16'h00F5 -> read returns the prior value, proto_err = 1; write to 16'h00EF succeeds.
- mem_state = 3 for 20 cycles with random addr/din -> no dout_valid, counters unchanged, proto_err = 0.

Source files
------------

// File: rtl/lc3_dmem_pkg.sv
// Shared types and constants for the LC3 data-memory responder.
package lc3_dmem_pkg;

  localparam int          DATA_W  = 16;
  localparam logic [15:0] CNT_MAX = 16'hFFFF;

  typedef enum logic [1:0] {
    MEM_RD   = 2'd0,
    MEM_RDI  = 2'd1,
    MEM_WR   = 2'd2,
    MEM_IDLE = 2'd3
  } mem_state_t;

  typedef enum logic [1:0] {
    IDLE,
    RD_WAIT,
    RESP
  } dmem_fsm_t;

endpackage

// File: rtl/lc3_dmem_responder_sat_counter.sv
// 16-bit saturating event counter with synchronous clear (clear wins over increment).
module lc3_dmem_sat_counter
  import lc3_dmem_pkg::*;
(
  input  logic              clock,
  input  logic              clr,
  input  logic              inc,
  output logic [DATA_W-1:0] count
);

  function automatic logic [DATA_W-1:0] sat_inc(input logic [DATA_W-1:0] v);
    return (v == CNT_MAX) ? v : v + 1'b1;
  endfunction

  always_ff @(posedge clock) begin
    if (clr)
      count <= '0;
    else if (inc)
      count <= sat_inc(count);
  end

endmodule

// File: rtl/lc3_dmem_responder.sv
// LC3 MemAccess data-memory responder: zero-latency writes, reads after READ_LATENCY cycles.
// Optional macro DMEM_WRITE_PROTECT_EN blocks writes to addresses >= PROT_BASE.
module lc3_dmem_responder
  import lc3_dmem_pkg::*;
#(
  parameter int          ADDR_WIDTH   = 8,
  parameter int          READ_LATENCY = 1,
  parameter logic [15:0] PROT_BASE    = 16'h00F0
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [15:0]       DMem_addr,
  input  logic [15:0]       DMem_din,
  input  logic              DMem_rd,
  input  logic [1:0]        mem_state,
  output logic [15:0]       DMem_dout,
  output logic              dout_valid,
  output logic              busy,
  output logic [15:0]       rd_count,
  output logic [15:0]       wr_count,
  output logic              proto_err
);

  localparam logic [3:0] LAT_INIT = 4'(READ_LATENCY - 1);

  logic [DATA_W-1:0]     mem [2**ADDR_WIDTH];
  dmem_fsm_t             state, state_nxt;
  logic [3:0]            lat_cnt, lat_cnt_nxt;
  logic [ADDR_WIDTH-1:0] rd_addr_p1;
  logic                  rd_oor_p1;
  logic                  req, rd_req, wr_req, oor, wr_prot;
  logic                  latch_rd, wr_en, rsp_en, err_set;
  logic [DATA_W-1:0]     rd_data;
  mem_state_t            ms;

  assign ms     = mem_state_t'(mem_state);
  assign req    = (ms != MEM_IDLE);
  assign rd_req = ((ms == MEM_RD) || (ms == MEM_RDI)) && DMem_rd;
  assign wr_req = (ms == MEM_WR) && !DMem_rd;
  assign oor    = ((DMem_addr >> ADDR_WIDTH) != 16'd0);

`ifdef DMEM_WRITE_PROTECT_EN
  assign wr_prot = (DMem_addr >= PROT_BASE);
`else
  // Feature disabled: PROT_BASE referenced only to keep the parameter live.
  assign wr_prot = 1'b0 & (DMem_addr >= PROT_BASE);
`endif

  always_comb begin
    state_nxt   = state;
    lat_cnt_nxt = lat_cnt;
    latch_rd    = 1'b0;
    wr_en       = 1'b0;
    rsp_en      = 1'b0;
    err_set     = 1'b0;
    case (state)
      IDLE: begin
        if (rd_req) begin
          latch_rd    = 1'b1;
          err_set     = oor;
          lat_cnt_nxt = LAT_INIT;
          state_nxt   = (READ_LATENCY == 1) ? RESP : RD_WAIT;
        end else if (wr_req) begin
          if (oor || wr_prot)
            err_set = 1'b1;
          else
            wr_en = 1'b1;
        end else if (req) begin
          err_set = 1'b1;
        end
      end
      RD_WAIT: begin
        err_set = req;
        if (lat_cnt <= 4'd1) begin
          lat_cnt_nxt = 4'd0;
          state_nxt   = RESP;
        end else begin
          lat_cnt_nxt = lat_cnt - 4'd1;
        end
      end
      RESP: begin
        err_set   = req;
        rsp_en    = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= IDLE;
      lat_cnt    <= 4'd0;
      DMem_dout  <= 16'h0000;
      dout_valid <= 1'b0;
      proto_err  <= 1'b0;
    end else begin
      state      <= state_nxt;
      lat_cnt    <= lat_cnt_nxt;
      dout_valid <= rsp_en;
      if (rsp_en)
        DMem_dout <= rd_data;
      if (err_set)
        proto_err <= 1'b1;
    end
  end

  // Storage is never cleared by reset; reset only blocks a same-edge write.
  always_ff @(posedge clock) begin
    if (latch_rd) begin
      rd_addr_p1 <= DMem_addr[ADDR_WIDTH-1:0];
      rd_oor_p1  <= oor;
    end
    if (wr_en && !reset)
      mem[DMem_addr[ADDR_WIDTH-1:0]] <= DMem_din;
  end

  assign rd_data = rd_oor_p1 ? 16'h0000 : mem[rd_addr_p1];
  assign busy    = (state != IDLE);

  lc3_dmem_sat_counter u_rd_cnt (
    .clock (clock),
    .clr   (reset),
    .inc   (rsp_en),
    .count (rd_count)
  );

  lc3_dmem_sat_counter u_wr_cnt (
    .clock (clock),
    .clr   (reset),
    .inc   (wr_en),
    .count (wr_count)
  );

endmodule

// File: tb/tb_lc3_dmem_responder.sv
// Directed self-checking bench for lc3_dmem_responder with READ_LATENCY = 3.
module tb_lc3_dmem_responder;
  localparam int LAT = 3;

  logic        clock = 1'b0;
  logic        reset;
  logic [15:0] DMem_addr, DMem_din;
  logic        DMem_rd;
  logic [1:0]  mem_state;
  logic [15:0] DMem_dout, rd_count, wr_count;
  logic        dout_valid, busy, proto_err;

  int n_chk  = 0;
  int n_fail = 0;

  lc3_dmem_responder #(.ADDR_WIDTH(8), .READ_LATENCY(LAT), .PROT_BASE(16'h00F0)) dut (
    .clock      (clock),
    .reset      (reset),
    .DMem_addr  (DMem_addr),
    .DMem_din   (DMem_din),
    .DMem_rd    (DMem_rd),
    .mem_state  (mem_state),
    .DMem_dout  (DMem_dout),
    .dout_valid (dout_valid),
    .busy       (busy),
    .rd_count   (rd_count),
    .wr_count   (wr_count),
    .proto_err  (proto_err)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_chk++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic go_idle();
    mem_state = 2'd3;
    DMem_rd   = 1'b1;
  endtask

  task automatic do_write(input logic [15:0] a, input logic [15:0] d);
    mem_state = 2'd2; DMem_rd = 1'b0; DMem_addr = a; DMem_din = d;
    tick();
    go_idle();
  endtask

  task automatic do_read(input string tag, input logic [15:0] a, input logic [15:0] exp);
    mem_state = 2'd0; DMem_rd = 1'b1; DMem_addr = a;
    tick();
    go_idle();
    chk({tag, "_busy"}, {15'd0, busy}, 16'd1);
    for (int i = 1; i < LAT; i++) begin
      chk({tag, "_early_valid"}, {15'd0, dout_valid}, 16'd0);
      tick();
    end
    chk({tag, "_early_valid"}, {15'd0, dout_valid}, 16'd0);
    tick();
    chk({tag, "_valid"}, {15'd0, dout_valid}, 16'd1);
    chk({tag, "_data"}, DMem_dout, exp);
    chk({tag, "_busy_done"}, {15'd0, busy}, 16'd0);
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  initial begin
    int saw_valid;
    reset = 1'b1; DMem_addr = '0; DMem_din = '0;
    go_idle();
    tick(); tick();
    chk("rst_dout", DMem_dout, 16'h0000);
    chk("rst_valid", {15'd0, dout_valid}, 16'd0);
    chk("rst_busy", {15'd0, busy}, 16'd0);
    chk("rst_rdcnt", rd_count, 16'd0);
    chk("rst_wrcnt", wr_count, 16'd0);
    chk("rst_err", {15'd0, proto_err}, 16'd0);
    reset = 1'b0;
    tick();

    // Write then read-after-write
    do_write(16'h0010, 16'hBEEF);
    chk("wr_cnt1", wr_count, 16'd1);
    chk("wr_novalid", {15'd0, dout_valid}, 16'd0);
    do_read("raw", 16'h0010, 16'hBEEF);
    chk("raw_rdcnt", rd_count, 16'd1);
    tick();
    chk("pulse_len", {15'd0, dout_valid}, 16'd0);
    chk("dout_hold", DMem_dout, 16'hBEEF);
    chk("raw_err", {15'd0, proto_err}, 16'd0);

    // Read request issued while busy
    mem_state = 2'd0; DMem_rd = 1'b1; DMem_addr = 16'h0010;
    tick();
    tick();
    go_idle();
    chk("busy_err", {15'd0, proto_err}, 16'd1);
    tick(); tick();
    chk("busy_valid", {15'd0, dout_valid}, 16'd1);
    chk("busy_data", DMem_dout, 16'hBEEF);
    tick(); tick(); tick(); tick();
    chk("busy_rdcnt", rd_count, 16'd2);
    chk("busy_novalid", {15'd0, dout_valid}, 16'd0);

    // Illegal mem_state/DMem_rd combination: no write
    pulse_reset();
    chk("rst2_err", {15'd0, proto_err}, 16'd0);
    chk("rst2_rdcnt", rd_count, 16'd0);
    mem_state = 2'd2; DMem_rd = 1'b1; DMem_addr = 16'h0010; DMem_din = 16'h0000;
    tick();
    go_idle();
    chk("bad_err", {15'd0, proto_err}, 16'd1);
    chk("bad_wrcnt", wr_count, 16'd0);
    do_read("bad_rd", 16'h0010, 16'hBEEF);

    // Out-of-range address
    pulse_reset();
    do_write(16'h0000, 16'h1111);
    chk("oor_pre_wr", wr_count, 16'd1);
    chk("oor_pre_err", {15'd0, proto_err}, 16'd0);
    do_read("oor_rd", 16'h0100, 16'h0000);
    chk("oor_err", {15'd0, proto_err}, 16'd1);
    chk("oor_rdcnt", rd_count, 16'd1);
    do_write(16'h0100, 16'h5555);
    chk("oor_wrcnt", wr_count, 16'd1);
    do_read("oor_alias", 16'h0000, 16'h1111);

    // Reset during RD_WAIT
    mem_state = 2'd0; DMem_rd = 1'b1; DMem_addr = 16'h0010;
    tick();
    go_idle();
    tick();
    chk("mid_busy", {15'd0, busy}, 16'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("mid_busy0", {15'd0, busy}, 16'd0);
    chk("mid_valid", {15'd0, dout_valid}, 16'd0);
    chk("mid_dout", DMem_dout, 16'h0000);
    chk("mid_rdcnt", rd_count, 16'd0);
    chk("mid_wrcnt", wr_count, 16'd0);
    tick();
    chk("mid_aborted", {15'd0, dout_valid}, 16'd0);
    tick();
    chk("mid_aborted2", {15'd0, dout_valid}, 16'd0);
    chk("mid_rdcnt2", rd_count, 16'd0);
    do_read("retain", 16'h0010, 16'hBEEF);

    // Write-protect region
    pulse_reset();
    do_write(16'h00F5, 16'h1234);
`ifdef DMEM_WRITE_PROTECT_EN
    chk("prot_err", {15'd0, proto_err}, 16'd1);
    chk("prot_wrcnt", wr_count, 16'd0);
    mem_state = 2'd0; DMem_rd = 1'b1; DMem_addr = 16'h00F5;
    tick(); go_idle();
    for (int i = 0; i < LAT; i++) tick();
    chk("prot_valid", {15'd0, dout_valid}, 16'd1);
    chk("prot_kept", {15'd0, (DMem_dout !== 16'h1234)}, 16'd1);
    do_write(16'h00EF, 16'h4321);
    chk("unprot_wrcnt", wr_count, 16'd1);
    do_read("unprot_rd", 16'h00EF, 16'h4321);
`else
    chk("noprot_err", {15'd0, proto_err}, 16'd0);
    chk("noprot_wrcnt", wr_count, 16'd1);
    do_read("noprot_rd", 16'h00F5, 16'h1234);
`endif

    // Idle bus with random address/data
    pulse_reset();
    do_write(16'h0020, 16'h7777);
    saw_valid = 0;
    for (int i = 0; i < 20; i++) begin
      mem_state = 2'd3;
      DMem_rd   = 1'($urandom_range(0, 1));
      DMem_addr = 16'($urandom);
      DMem_din  = 16'($urandom);
      tick();
      if (dout_valid) saw_valid++;
    end
    go_idle();
    chk("idle_valid", 16'(saw_valid), 16'd0);
    chk("idle_rdcnt", rd_count, 16'd0);
    chk("idle_wrcnt", wr_count, 16'd1);
    chk("idle_err", {15'd0, proto_err}, 16'd0);
    do_read("idle_rd", 16'h0020, 16'h7777);

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

endmodule
